// File: rtl/cpu_bus_controller_pkg.sv
// Address map, target/state enums and helpers shared by the CPU bus controller
// and its address decoder.
package bus_pkg;

    typedef enum logic [1:0] {
        TGT_RAM  = 2'd0,
        TGT_PPU  = 2'd1,
        TGT_IO   = 2'd2,
        TGT_CART = 2'd3
    } target_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RAM_WAIT = 2'd1,
        ST_EXT_WAIT = 2'd2,
        ST_HOLD     = 2'd3
    } state_e;

    // Inclusive upper bounds of each decode window; anything above IO is cartridge.
    localparam logic [15:0] RAM_LAST      = 16'h1FFF;
    localparam logic [15:0] PPU_LAST      = 16'h3FFF;
    localparam logic [15:0] IO_LAST       = 16'h401F;
    localparam logic [15:0] PPU_FOLD_MASK = 16'h2007;

    localparam logic [1:0] SEL_PPU  = 2'd0;
    localparam logic [1:0] SEL_IO   = 2'd1;
    localparam logic [1:0] SEL_CART = 2'd2;

    function automatic logic [1:0] ext_sel_of(input target_e t);
        case (t)
            TGT_PPU: return SEL_PPU;
            TGT_IO:  return SEL_IO;
            default: return SEL_CART;
        endcase
    endfunction

endpackage

// File: rtl/cpu_bus_controller_if.sv
// Bus bundle between the controller (master) and the CPU core, work RAM and
// external target bus (slave side). Suffixes are from the controller's view.
interface cpu_bus_if #(
    parameter int RAM_ADDR_WIDTH = 11
) ();

    logic [15:0]               cpu_address_i;
    logic                      cpu_address_valid_i;
    logic                      cpu_write_i;
    logic [7:0]                cpu_data_i;
    logic [7:0]                cpu_data_o;
    logic                      cpu_data_valid_o;

    logic [RAM_ADDR_WIDTH-1:0] ram_address_o;
    logic                      ram_read_o;
    logic                      ram_write_o;
    logic [7:0]                ram_data_o;
    logic [7:0]                ram_data_i;

    logic [1:0]                ext_sel_o;
    logic                      ext_req_o;
    logic [15:0]               ext_address_o;
    logic                      ext_write_o;
    logic [7:0]                ext_data_o;
    logic [7:0]                ext_data_i;
    logic                      ext_ack_i;

    modport master (
        input  cpu_address_i, cpu_address_valid_i, cpu_write_i, cpu_data_i,
        output cpu_data_o, cpu_data_valid_o,
        output ram_address_o, ram_read_o, ram_write_o, ram_data_o,
        input  ram_data_i,
        output ext_sel_o, ext_req_o, ext_address_o, ext_write_o, ext_data_o,
        input  ext_data_i, ext_ack_i
    );

    modport slave (
        output cpu_address_i, cpu_address_valid_i, cpu_write_i, cpu_data_i,
        input  cpu_data_o, cpu_data_valid_o,
        input  ram_address_o, ram_read_o, ram_write_o, ram_data_o,
        output ram_data_i,
        input  ext_sel_o, ext_req_o, ext_address_o, ext_write_o, ext_data_o,
        output ext_data_i, ext_ack_i
    );

endinterface

// File: rtl/cpu_bus_controller_decoder.sv
// Combinational CPU address decode: target, work-RAM index and the external
// address with PPU registers folded onto their 8-byte window.
module cpu_bus_decoder
    import bus_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 11
) (
    input  logic [15:0]               i_address,
    output target_e                   o_target,
    output logic [RAM_ADDR_WIDTH-1:0] o_ram_index,
    output logic [15:0]               o_ext_address
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the if-chain infers a latch.
        o_target      = TGT_CART;
        o_ext_address = i_address;
        if (i_address <= RAM_LAST) begin
            o_target = TGT_RAM;
        end else if (i_address <= PPU_LAST) begin
            o_target      = TGT_PPU;
            o_ext_address = i_address & PPU_FOLD_MASK;
        end else if (i_address <= IO_LAST) begin
            o_target = TGT_IO;
        end
    end

    assign o_ram_index = i_address[RAM_ADDR_WIDTH-1:0];

endmodule

// File: rtl/cpu_bus_controller.sv
// CPU bus controller: routes each CPU access to work RAM or the shared external
// req/ack bus, then holds the result until the CPU changes its request.
module cpu_bus_controller
    import bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int RAM_ADDR_WIDTH = 11
) (
    input  logic      clock_i,
    input  logic      reset_ni,
    cpu_bus_if.master bus
);

    localparam int                 CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    target_e                   w_target;
    logic [RAM_ADDR_WIDTH-1:0] w_ram_index;
    logic [15:0]               w_ext_address;
    logic                      w_leave_hold;

    state_e                    r_state;
    logic [15:0]               r_addr;
    logic                      r_write;
    logic [7:0]                r_cpu_data;
    logic                      r_valid;
    logic [7:0]                r_open_bus;
    logic [RAM_ADDR_WIDTH-1:0] r_ram_address;
    logic                      r_ram_read;
    logic                      r_ram_write;
    logic [7:0]                r_ram_data;
    logic [1:0]                r_ext_sel;
    logic                      r_ext_req;
    logic [15:0]               r_ext_address;
    logic                      r_ext_write;
    logic [7:0]                r_ext_data;
    logic [CNT_W-1:0]          r_count;

    cpu_bus_decoder #(
        .RAM_ADDR_WIDTH (RAM_ADDR_WIDTH)
    ) u_decoder (
        .i_address     (bus.cpu_address_i),
        .o_target      (w_target),
        .o_ram_index   (w_ram_index),
        .o_ext_address (w_ext_address)
    );

    // Any change to the CPU's request ends the hold; an unchanged one is never re-issued.
    assign w_leave_hold = !bus.cpu_address_valid_i
                        || (bus.cpu_address_i != r_addr)
                        || (bus.cpu_write_i != r_write);

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_write       <= 1'b0;
            r_cpu_data    <= '0;
            r_valid       <= 1'b0;
            r_open_bus    <= '0;
            r_ram_address <= '0;
            r_ram_read    <= 1'b0;
            r_ram_write   <= 1'b0;
            r_ram_data    <= '0;
            r_ext_sel     <= '0;
            r_ext_req     <= 1'b0;
            r_ext_address <= '0;
            r_ext_write   <= 1'b0;
            r_ext_data    <= '0;
            r_count       <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            r_ram_read  <= 1'b0;
            r_ram_write <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.cpu_address_valid_i) begin
                        r_addr  <= bus.cpu_address_i;
                        r_write <= bus.cpu_write_i;
                        if (w_target == TGT_RAM) begin
                            r_ram_address <= w_ram_index;
                            if (bus.cpu_write_i) begin
                                r_ram_write <= 1'b1;
                                r_ram_data  <= bus.cpu_data_i;
                                r_state     <= ST_HOLD;
                            end else begin
                                r_ram_read <= 1'b1;
                                r_state    <= ST_RAM_WAIT;
                            end
                        end else begin
                            r_ext_req     <= 1'b1;
                            r_ext_sel     <= ext_sel_of(w_target);
                            r_ext_address <= w_ext_address;
                            r_ext_write   <= bus.cpu_write_i;
                            r_ext_data    <= bus.cpu_data_i;
                            r_count       <= '0;
                            r_state       <= ST_EXT_WAIT;
                        end
                    end
                end
                ST_RAM_WAIT: begin
                    r_cpu_data <= bus.ram_data_i;
                    r_open_bus <= bus.ram_data_i;
                    r_state    <= ST_HOLD;
                end
                ST_EXT_WAIT: begin
                    // Ack is tested first so it wins over a timeout on the same edge.
                    if (bus.ext_ack_i) begin
                        r_ext_req <= 1'b0;
                        if (!r_write) begin
                            r_cpu_data <= bus.ext_data_i;
                            r_open_bus <= bus.ext_data_i;
                        end
                        r_state <= ST_HOLD;
                    end else if (r_count == CNT_LAST) begin
                        r_ext_req <= 1'b0;
                        if (!r_write) begin
                            r_cpu_data <= r_open_bus;
                        end
                        r_state <= ST_HOLD;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (w_leave_hold) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_valid <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cpu_data_o       = r_cpu_data;
    assign bus.cpu_data_valid_o = r_valid;
    assign bus.ram_address_o    = r_ram_address;
    assign bus.ram_read_o       = r_ram_read;
    assign bus.ram_write_o      = r_ram_write;
    assign bus.ram_data_o       = r_ram_data;
    assign bus.ext_sel_o        = r_ext_sel;
    assign bus.ext_req_o        = r_ext_req;
    assign bus.ext_address_o    = r_ext_address;
    assign bus.ext_write_o      = r_ext_write;
    assign bus.ext_data_o       = r_ext_data;

endmodule

// File: doc/cpu_bus_controller.md
Name: cpu_bus_controller

Overview:
- Sits directly downstream of the CPU core. Takes the core's address/data/valid outputs and returns read data with a valid flag.
- Decodes the 16-bit CPU address space:
  - internal 2 KB work RAM, mirrored over $0000-$1FFF;
  - PPU registers, 8 bytes mirrored over $2000-$3FFF;
  - APU/IO at $4000-$401F;
  - cartridge at $4020-$FFFF.
- RAM has fixed latency. All other targets share one external req/ack bus, with a timeout that falls back to open-bus data.

Parameters:
- TIMEOUT_CYCLES, 64: number of EXT_WAIT cycles without ack before completing with open-bus data. Must be at least 2.
- RAM_ADDR_WIDTH, 11: width of the work RAM index (2 KB).

Ports:
- clock_i  input  1  system clock
- reset_ni  input  1  asynchronous active-low reset
- cpu_address_i  input  16  CPU address
- cpu_address_valid_i  input  1  CPU address valid
- cpu_write_i  input  1  high = write request (CPU data_valid_o)
- cpu_data_i  input  8  CPU write data
- cpu_data_o  output  8  read data to CPU
- cpu_data_valid_o  output  1  transaction complete, data valid (level)
- ram_address_o  output  RAM_ADDR_WIDTH  work RAM index
- ram_read_o  output  1  RAM read strobe
- ram_write_o  output  1  RAM write strobe
- ram_data_o  output  8  RAM write data
- ram_data_i  input  8  RAM read data, valid the cycle after ram_read_o
- ext_sel_o  output  2  target select: 0 = PPU, 1 = IO, 2 = CART
- ext_req_o  output  1  external request, held until ack or timeout
- ext_address_o  output  16  external address; PPU addresses are folded to $2000 | addr[2:0]
- ext_write_o  output  1  external write
- ext_data_o  output  8  external write data
- ext_data_i  input  8  external read data, valid with ext_ack_i
- ext_ack_i  input  1  external completion

Behaviour:
- Clock and reset: one clock, clock_i. Reset reset_ni is asynchronous and active-low.
- Reset state: all outputs 0, state IDLE, open-bus latch 0.
- States: IDLE, RAM_WAIT, EXT_WAIT, HOLD.
- IDLE:
  - On a clock edge with cpu_address_valid_i = 1, latch address, write flag and write data, then decode.
  - RAM target:
    - Drive ram_address_o = addr[10:0].
    - Write: pulse ram_write_o for one cycle with ram_data_o = cpu_data_i, go to HOLD.
    - Read: pulse ram_read_o for one cycle, go to RAM_WAIT.
  - Other targets: assert ext_req_o with ext_sel_o, ext_address_o, ext_write_o and ext_data_o, clear the timeout counter, go to EXT_WAIT.
- RAM_WAIT: capture ram_data_i into cpu_data_o and the open-bus latch, go to HOLD.
- EXT_WAIT:
  - On ext_ack_i: drop ext_req_o. On a read, capture ext_data_i into cpu_data_o and the open-bus latch. Go to HOLD.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES-1: drop ext_req_o; on a read, return the open-bus latch on cpu_data_o. Go to HOLD.
  - If ack arrives on the same cycle as the timeout, the ack wins.
- HOLD:
  - cpu_data_valid_o = 1 and cpu_data_o is stable, so the CPU can sample on its divided clock.
  - Leave to IDLE, dropping cpu_data_valid_o on the same edge, when any of these occurs:
    - cpu_address_valid_i = 0;
    - cpu_address_i differs from the latched address;
    - cpu_write_i differs from the latched write flag.
  - A new request is accepted no earlier than the following edge.
  - A repeated access to the same address is not re-issued.
- Writes also complete through HOLD; cpu_data_o is unchanged on writes.
- Latency from the accepting edge to cpu_data_valid_o high:
  - RAM read: 2 edges.
  - RAM write: 1 edge.
  - External access: ack edge + 1.
- Inputs are ignored outside IDLE (no queueing).
- Reset during RAM_WAIT or EXT_WAIT: ext_req_o and all strobes drop immediately (asynchronously); the in-flight transaction is abandoned.

Decomposition:
- Shared package bus_pkg holds:
  - target enum (RAM, PPU, IO, CART);
  - state enum;
  - range constants $1FFF, $3FFF, $401F;
  - PPU fold mask 16'h2007.
- Sub-module cpu_bus_decoder: purely combinational. Maps address to target enum, RAM index and folded external address.

Test Plan:
- RAM read: preload RAM[$001] = 8'h5A, CPU reads $0801 → ram_address_o = 11'h001, ram_read_o pulses one cycle, cpu_data_o = 8'h5A, cpu_data_valid_o high 2 edges after accept.
- PPU mirror write: CPU writes 8'h3F to $3FFE, ack 3 cycles later → ext_sel_o = 0, ext_address_o = 16'h2006, ext_write_o = 1, ext_data_o = 8'h3F; cpu_data_valid_o rises the edge after ack.
- Cartridge read: CPU reads $FFFC, ext_data_i = 8'h00 with ack 5 cycles later → ext_sel_o = 2, ext_address_o = 16'hFFFC. Then read $FFFD with data 8'h80 → cpu_data_o = 8'h80.
- Timeout: after a RAM read of 8'hA7, CPU reads $4016 with no ack → ext_req_o drops after 64 cycles, cpu_data_o = 8'hA7, cpu_data_valid_o = 1. Ack on exactly cycle 64 instead → ack data is returned.
- Hold and re-issue: address held at $0000 for 20 cycles → exactly one ram_read_o. Address changes to $0001 → valid drops the next edge and a new ram_read_o follows.
- Reset mid-operation: assert reset_ni low during EXT_WAIT → ext_req_o and cpu_data_valid_o go to 0 before the next clock edge. After release, state is IDLE and the next request is served normally.
